// File: rtl/tube_mmio.sv
// tube_mmio: bus-mapped register window driving a four-digit seven-segment tube scan.
// Define TUBE_MMIO_BLANK_EN to enable leading-zero blanking controlled by CTRL[1].
module tube_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int unsigned SCAN_DIV  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [15:0] write,
  input  logic        we,
  input  logic        re,
  output logic [15:0] read,
  output logic        ready,
  output logic [3:0]  tubeDig,
  output logic [7:0]  tubeSeg
);

  localparam int unsigned        CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state;
  logic [1:0]         off_q;
  logic               we_q;
  logic [15:0]        wdata_q;

  logic [15:0]        data;
  logic [3:0]         dots;
  logic               en;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         idx;

  logic [31:0]        offset;
  logic               hit;
  logic [15:0]        data_n;
  logic [3:0]         dots_n;
  logic               en_n;
  logic               blk_rd;
  logic [15:0]        rd_n;
  logic [3:0]         nib;
  logic               blank;
  logic [3:0]         dig_n;
  logic [7:0]         seg_n;

`ifdef TUBE_MMIO_BLANK_EN
  logic               blk;
  logic               blk_n;
`endif

  // gfedcba, active-high
  function automatic logic [6:0] hexseg(input logic [3:0] n);
    case (n)
      4'h0: hexseg = 7'h3F;
      4'h1: hexseg = 7'h06;
      4'h2: hexseg = 7'h5B;
      4'h3: hexseg = 7'h4F;
      4'h4: hexseg = 7'h66;
      4'h5: hexseg = 7'h6D;
      4'h6: hexseg = 7'h7D;
      4'h7: hexseg = 7'h07;
      4'h8: hexseg = 7'h7F;
      4'h9: hexseg = 7'h6F;
      4'hA: hexseg = 7'h77;
      4'hB: hexseg = 7'h7C;
      4'hC: hexseg = 7'h39;
      4'hD: hexseg = 7'h5E;
      4'hE: hexseg = 7'h79;
      default: hexseg = 7'h71;
    endcase
  endfunction

  // Window decode; wrap-around subtraction keeps the compare a single magnitude check
  always_comb begin
    offset = addr - BASE_ADDR;
    hit    = (re | we) && (offset < 32'd4);
  end

  // Register values after the latched write (if any), and the read mux over them
  always_comb begin
    data_n = data;
    dots_n = dots;
    en_n   = en;
`ifdef TUBE_MMIO_BLANK_EN
    blk_n  = blk;
`endif
    if (state == ACCESS && we_q) begin
      case (off_q)
        2'd0: data_n = wdata_q;
        2'd1: dots_n = wdata_q[3:0];
        2'd2: begin
          en_n = wdata_q[0];
`ifdef TUBE_MMIO_BLANK_EN
          blk_n = wdata_q[1];
`endif
        end
        default: ;
      endcase
    end
`ifdef TUBE_MMIO_BLANK_EN
    blk_rd = blk_n;
`else
    blk_rd = 1'b0;
`endif
    case (off_q)
      2'd0:    rd_n = data_n;
      2'd1:    rd_n = {12'h000, dots_n};
      2'd2:    rd_n = {14'h0000, blk_rd, en_n};
      default: rd_n = {14'h0000, idx};
    endcase
  end

  // Next scan-output values for the digit currently indexed
  always_comb begin
    nib = 4'(data >> {idx, 2'b00});
`ifdef TUBE_MMIO_BLANK_EN
    blank = blk && (idx != 2'd0) && ((data >> {idx, 2'b00}) == 16'h0000);
`else
    blank = 1'b0;
`endif
    if (!en) begin
      dig_n = 4'hF;
      seg_n = 8'hFF;
    end else begin
      dig_n = ~(4'b0001 << idx);
      seg_n = blank ? {~dots[idx], 7'h7F} : ~{dots[idx], hexseg(nib)};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      off_q   <= 2'd0;
      we_q    <= 1'b0;
      wdata_q <= 16'h0000;
      ready   <= 1'b0;
      read    <= 16'h0000;
      data    <= 16'h0000;
      dots    <= 4'h0;
      en      <= 1'b1;
`ifdef TUBE_MMIO_BLANK_EN
      blk     <= 1'b0;
`endif
      cnt     <= '0;
      idx     <= 2'd0;
      tubeDig <= 4'b1110;
      tubeSeg <= 8'hC0;
    end else begin
      data <= data_n;
      dots <= dots_n;
      en   <= en_n;
`ifdef TUBE_MMIO_BLANK_EN
      blk  <= blk_n;
`endif

      // Free-running prescaler, independent of bus and enable
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      tubeDig <= dig_n;
      tubeSeg <= seg_n;

      case (state)
        IDLE: begin
          if (hit) begin
            off_q   <= offset[1:0];
            we_q    <= we;
            wdata_q <= write;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          read  <= rd_n;
          ready <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (!re && !we) begin
            ready <= 1'b0;
            read  <= 16'h0000;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tube_mmio.sv
// Randomized bench for tube_mmio against a transaction-level register/scan model.
module tb_tube_mmio;

  localparam int unsigned D    = 4;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;
`ifdef TUBE_MMIO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr;
  logic [15:0] write;
  logic        we;
  logic        re;
  logic [15:0] read;
  logic        ready;
  logic [3:0]  tubeDig;
  logic [7:0]  tubeSeg;

  tube_mmio #(.BASE_ADDR(BASE), .SCAN_DIV(D)) dut (
    .clk(clk), .rst(rst), .addr(addr), .write(write), .we(we), .re(re),
    .read(read), .ready(ready), .tubeDig(tubeDig), .tubeSeg(tubeSeg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [15:0] m_data;
  logic [3:0]  m_dots;
  logic        m_en;
  logic        m_blk;
  logic        exp_ready;
  logic [15:0] exp_read;
  logic [3:0]  pred_dig;
  logic [7:0]  pred_seg;
  logic [6:0]  hex_tab [16];
  logic [7:0]  seen_seg [4];
  int          ecount;

  // Clock edges since reset release; scan index after n edges is (n/D)%4
  always @(posedge clk or negedge rst)
    if (!rst) ecount <= 0;
    else      ecount <= ecount + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  function automatic logic [3:0] m_dig(input int i);
    if (!m_en) return 4'hF;
    return ~(4'b0001 << i);
  endfunction

  function automatic logic [7:0] m_seg(input int i);
    logic [3:0] n;
    n = 4'(m_data >> (4 * i));
    if (!m_en) return 8'hFF;
    if (BLANK && m_blk && i > 0 && (m_data >> (4 * i)) == 16'h0000)
      return m_dots[i] ? 8'h7F : 8'hFF;
    return ~{m_dots[i], hex_tab[n]};
  endfunction

  task automatic model_reset();
    m_data    = 16'h0000;
    m_dots    = 4'h0;
    m_en      = 1'b1;
    m_blk     = 1'b0;
    exp_ready = 1'b0;
    exp_read  = 16'h0000;
  endtask

  // Checks every output at every falling edge
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_dig", 32'(tubeDig), 32'h0000_000E);
        chk("rst_seg", 32'(tubeSeg), 32'h0000_00C0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_read", 32'(read), 32'h0);
      end else begin
        chk("dig", 32'(tubeDig), 32'(pred_dig));
        chk("seg", 32'(tubeSeg), 32'(pred_seg));
        chk("ready", 32'(ready), 32'(exp_ready));
        chk("read", 32'(read), 32'(exp_read));
      end
      pred_dig = m_dig((ecount / D) % 4);
      pred_seg = m_seg((ecount / D) % 4);
    end
  endtask

  task automatic xact(input logic [31:0] a, input logic w, input logic r,
                      input logic [15:0] wd, output logic [15:0] got);
    logic [31:0] off;
    int          e1;
    got = 16'h0000;
    @(negedge clk);
    addr = a; write = wd; we = w; re = r;
    off = a - BASE;
    if (!(w || r) || off > 32'd3) begin
      repeat (4) @(negedge clk);
      we = 1'b0; re = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e1 = ecount;
    @(posedge clk); #1;
    if (w) begin
      case (off[1:0])
        2'd0: m_data = wd;
        2'd1: m_dots = wd[3:0];
        2'd2: begin m_en = wd[0]; m_blk = BLANK && wd[1]; end
        default: ;
      endcase
    end
    case (off[1:0])
      2'd0:    exp_read = m_data;
      2'd1:    exp_read = {12'h000, m_dots};
      2'd2:    exp_read = {14'h0000, m_blk, m_en};
      default: exp_read = 16'((e1 / D) % 4);
    endcase
    exp_ready = 1'b1;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    got = read;
    we = 1'b0; re = 1'b0;
    addr = $urandom; write = 16'($urandom);
    @(posedge clk); #1;
    exp_ready = 1'b0;
    exp_read  = 16'h0000;
  endtask

  // Record the segment pattern shown on each digit over a full scan
  task automatic watch();
    for (int k = 0; k < 4; k++) seen_seg[k] = 8'h00;
    for (int c = 0; c < int'(4 * D + 4); c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        if (tubeDig == 4'(~(4'b0001 << k))) seen_seg[k] = tubeSeg;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] got;
    logic [31:0] ra;
    int          sel;
    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_reset();
    pred_dig = 4'hE;
    pred_seg = 8'hC0;
    addr = 32'h0; write = 16'h0; we = 1'b0; re = 1'b0;
    fork
      compare_loop();
    join_none

    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);

    // Hex display of 12AF across the four digits
    xact(BASE, 1'b1, 1'b0, 16'h12AF, got);
    watch();
    chk("hex_d0_F", 32'(seen_seg[0]), 32'h8E);
    chk("hex_d1_A", 32'(seen_seg[1]), 32'h88);
    chk("hex_d2_2", 32'(seen_seg[2]), 32'hA4);
    chk("hex_d3_1", 32'(seen_seg[3]), 32'hF9);

    // STATUS read during slot 2
    for (int c = 0; c < int'(8 * D); c++) begin
      @(posedge clk); #1;
      if (ecount % (4 * D) == 2 * D) break;
    end
    xact(BASE + 32'd3, 1'b0, 1'b1, 16'h0000, got);
    chk("status_slot2", 32'(got), 32'h2);

    // Out-of-window read never handshakes
    xact(BASE + 32'd5, 1'b0, 1'b1, 16'h0000, got);

    // Decimal point on digit 0, then display disable
    xact(BASE, 1'b1, 1'b0, 16'h0001, got);
    xact(BASE + 32'd1, 1'b1, 1'b0, 16'hFFF1, got);
    watch();
    chk("dp_d0", 32'(seen_seg[0]), 32'h79);
    chk("nodp_d1", 32'(seen_seg[1]), 32'hC0);
    xact(BASE + 32'd1, 1'b0, 1'b1, 16'h0000, got);
    chk("dots_rd", 32'(got), 32'h1);
    xact(BASE + 32'd2, 1'b1, 1'b0, 16'h0000, got);
    repeat (2) @(negedge clk);
    chk("off_dig", 32'(tubeDig), 32'hF);
    chk("off_seg", 32'(tubeSeg), 32'hFF);

    // Simultaneous read and write
    xact(BASE + 32'd2, 1'b1, 1'b0, 16'h0001, got);
    xact(BASE + 32'd1, 1'b1, 1'b0, 16'h0000, got);
    xact(BASE, 1'b1, 1'b1, 16'h00FF, got);
    chk("rw_data", 32'(got), 32'h00FF);

    // Leading-zero blanking
    xact(BASE + 32'd2, 1'b1, 1'b0, 16'h0003, got);
    xact(BASE, 1'b1, 1'b0, 16'h0042, got);
    watch();
    chk("blk_d0", 32'(seen_seg[0]), 32'hA4);
    chk("blk_d1", 32'(seen_seg[1]), 32'h99);
    chk("blk_d2", 32'(seen_seg[2]), BLANK ? 32'hFF : 32'hC0);
    chk("blk_d3", 32'(seen_seg[3]), BLANK ? 32'hFF : 32'hC0);
    xact(BASE + 32'd2, 1'b0, 1'b1, 16'h0000, got);
    chk("ctrl_rd", 32'(got), BLANK ? 32'h3 : 32'h1);

    // Random traffic, hits and misses
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       ra = BASE + 32'(sel);
      else if (sel == 6) ra = BASE - 32'd1;
      else if (sel == 7) ra = $urandom;
      else               ra = BASE + 32'($urandom_range(0, 3));
      sel = $urandom_range(0, 3);
      xact(ra, sel[1], sel[0], 16'($urandom), got);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset while the acknowledge is held
    xact(BASE + 32'd2, 1'b1, 1'b0, 16'h0001, got);
    @(negedge clk);
    addr = BASE; write = 16'hBEEF; we = 1'b1; re = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_data = 16'hBEEF; exp_read = 16'hBEEF; exp_ready = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    #1 chk("midrst_ready", 32'(ready), 32'h0);
    we = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    xact(BASE, 1'b0, 1'b1, 16'h0000, got);
    chk("midrst_data", 32'(got), 32'h0);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tube_mmio.md
Name: tube_mmio

Overview:
- Memory-mapped responder for the four-digit seven-segment tube display on the CPU memory bus.
- Answers the bus initiator's addr/we/re/ready handshake through a small register window.
- Independently time-multiplexes the four digits using an internal scan counter.
- Lets software drive the display directly, replacing the debug-switch mux in the board top.

Parameters:
- BASE_ADDR, 32'hFFFF_FF00: word address of register 0. The window is BASE_ADDR..BASE_ADDR+3.
- SCAN_DIV, 1000: clk cycles per digit slot. Legal range is ≥2.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low.
- addr  input  32  bus word address from the initiator.
- write  input  16  bus write data.
- we  input  1  write request.
- re  input  1  read request.
- read  output  16  read data. Valid while ready=1; 0 otherwise.
- ready  output  1  handshake acknowledge from this responder.
- tubeDig  output  4  digit enables; active-low, one-hot. Bit0 = rightmost digit.
- tubeSeg  output  8  segments; active-low, {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset (rst=0, async): FSM to IDLE. ready=0, read=0.
- Reset values: DATA=0, DOTS=0, CTRL=1 (enabled), scan counter=0, digit index=0.
- Reset outputs: tubeDig=4'b1110, tubeSeg=8'hC0 (digit 0 showing '0').
- Registers (offset = addr-BASE_ADDR):
  - 0 DATA: 16-bit R/W, four hex digits; [3:0] goes to digit 0.
  - 1 DOTS: [3:0] R/W, dp per digit. Upper bits read 0.
  - 2 CTRL: [0] enable R/W; [1] blank-leading-zeros (see feature). Other bits read 0.
  - 3 STATUS: read-only; [1:0] current digit index. Writes ignored.
- Hit = (re|we) && addr within window. Non-hits are ignored entirely: ready and read stay 0, and the FSM stays in IDLE.
- Handshake FSM, four-phase:
  - IDLE: on hit, latch offset/we/re/write and go to ACCESS.
  - ACCESS (1 cycle): perform the write, or capture read data. Go to DONE.
  - DONE: ready=1, read holds captured data. Stay until re=0 && we=0, then return to IDLE with ready=0 and read=0 that cycle.
- Latency: ready rises on the 2nd clock edge after the hit is first sampled.
- Bus stability: the initiator must hold addr/write/we/re stable until ready. The responder uses only the values latched in IDLE.
- re and we together: write takes priority. read returns the register value after the write.
- Write width rules: DOTS and CTRL take only their defined low bits. Writes to offset 3 still complete the handshake.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - On wrap, digit index increments 3→0 (mod 4).
  - The counter runs regardless of the bus and of enable.
- Display outputs are registered, updated on the cycle after the index changes:
  - tubeDig = ~(1<<index).
  - tubeSeg = ~{DOTS[index], hexseg(nibble)}.
  - hexseg (gfedcba, active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- CTRL[0]=0: tubeDig=4'hF and tubeSeg=8'hFF. The scan continues.
- A register write updates the displayed digit no later than the next scan-output register update.
- Reset mid-handshake: ready drops immediately. Written-but-unacknowledged data is lost; registers take reset values.

Optional Feature:
- Macro: TUBE_MMIO_BLANK_EN.
- Defined, and CTRL[1]=1: any digit above the most significant nonzero nibble is blanked (tubeDig asserted, tubeSeg=8'hFF unless its dp is set, in which case 8'h7F).
  - Digit 0 is never blanked.
  - DATA=0 displays a single '0'.
- Undefined: CTRL[1] is not stored, reads 0, and has no effect; all digits are always shown.

Test Plan:
- Reset, hold, release → tubeDig=1110, tubeSeg=C0, ready=0, read=0.
- Write: we=1, addr=BASE, write=16'h12AF, held until ready, then dropped → ready high on the 2nd edge, low the cycle after we=0. Over four scan slots with SCAN_DIV=4, tubeSeg sequence is 8E (F), 88 (A), A4 (2), F9 (1) on digits 0..3.
- Read: re at BASE+3 during slot 2 → read=16'h0002 while ready. Read at BASE+5 → ready never asserts, read=0.
- Write DOTS=4'b0001, then CTRL=0 → dp low on digit 0 only (F9→79 for '1'). After CTRL write, tubeDig=F and tubeSeg=FF.
- re and we together at BASE, write=16'h00FF → DATA=00FF, read=00FF at ready.
- Feature: with TUBE_MMIO_BLANK_EN, CTRL=3, DATA=16'h0042 → digits 2,3 show FF. Without the macro, the same stimulus shows C0 on digits 2,3 and CTRL reads 1.
- Reset mid-handshake: assert rst while in DONE → ready=0 at once; DATA reads 0 afterwards.
